// File: rtl/tick_seq_pkg.sv
// Shared types and defaults for the tick sequencer slice.
// Optional TICK_SEQ_AUTORELOAD_EN changes sequencer behaviour; nothing here depends on it.
package tick_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seqState_e;

    localparam int unsigned DEFAULT_PRESCALE_W = 26;
    localparam int unsigned DEFAULT_COUNT_W    = 16;

    // One-second tick period on the 50 MHz board clock.
    localparam int unsigned ONE_SEC_DIVISOR = 49_999_999;

endpackage

// File: rtl/div_frec_prog.sv
// Programmable divide-by-(D+1) prescaler; oTick flags the cycle where the counter equals D.
// Counter is held at zero whenever iEn is low.
module div_frec_prog
    import tick_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iEn,
    input  logic [PRESCALE_W-1:0] iDivisor,
    output logic                  oTick
);

    logic [PRESCALE_W-1:0] cntQ, cntD;

    assign oTick = iEn && (cntQ == iDivisor);

    always_comb begin
        cntD = '0;
        if (iEn && !oTick) begin
            cntD = cntQ + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// Timer controller sequencing div_frec_prog: latches D/N on start, ticks every D+1 cycles.
// Define TICK_SEQ_AUTORELOAD_EN for continuous reload (N=0 then means free-run).
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W,
    parameter int unsigned COUNT_W    = DEFAULT_COUNT_W
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic                  iStop,
    input  logic [PRESCALE_W-1:0] iDivisor,
    input  logic [COUNT_W-1:0]    iTicks,
    output logic                  oBusy,
    output logic                  oTick,
    output logic                  oDone,
    output logic [COUNT_W-1:0]    oCount
);

    seqState_e             stateQ, stateD;
    logic [PRESCALE_W-1:0] divQ, divD;
    logic [COUNT_W-1:0]    ticksQ, ticksD;
    logic [COUNT_W-1:0]    countQ, countD;
    logic [COUNT_W-1:0]    countInc;
    logic                  tickQ, tickD;
    logic                  doneQ, doneD;
    logic                  prescEn;
    logic                  wrap;

    // Gating with iStop keeps the prescaler from wrapping on an aborted edge.
    assign prescEn  = (stateQ == StRun) && !iStop;
    assign countInc = countQ + 1'b1;

    div_frec_prog #(
        .PRESCALE_W(PRESCALE_W)
    ) uPresc (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (prescEn),
        .iDivisor(divQ),
        .oTick   (wrap)
    );

    always_comb begin
        stateD = stateQ;
        divD   = divQ;
        ticksD = ticksQ;
        countD = countQ;
        tickD  = 1'b0;
        doneD  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (iStart && !iStop) begin
                    divD   = iDivisor;
                    ticksD = iTicks;
                    countD = '0;
`ifdef TICK_SEQ_AUTORELOAD_EN
                    stateD = StRun;
`else
                    stateD = (iTicks != '0) ? StRun : StDone;
`endif
                end
            end
            StRun: begin
                if (iStop) begin
                    stateD = StIdle;
                end else if (wrap) begin
                    tickD  = 1'b1;
                    countD = countInc;
`ifdef TICK_SEQ_AUTORELOAD_EN
                    if ((ticksQ != '0) && (countInc == ticksQ)) begin
                        doneD  = 1'b1;
                        countD = '0;
                    end
`else
                    if (countInc == ticksQ) begin
                        doneD  = 1'b1;
                        stateD = StDone;
                    end
`endif
                end
            end
            StDone: begin
                stateD = StIdle;
                // N=0 runs report completion on the way out; N>0 already pulsed it.
                if (!iStop && (ticksQ == '0)) begin
                    doneD = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ <= StIdle;
            divQ   <= '0;
            ticksQ <= '0;
            countQ <= '0;
            tickQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            divQ   <= divD;
            ticksQ <= ticksD;
            countQ <= countD;
            tickQ  <= tickD;
            doneQ  <= doneD;
        end
    end

    assign oBusy  = (stateQ != StIdle);
    assign oTick  = tickQ;
    assign oDone  = doneQ;
    assign oCount = countQ;

endmodule
